// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA test-pattern source.
package vga_pkg;

    typedef enum logic [2:0] {
        MODE_RED     = 3'd0,
        MODE_GREEN   = 3'd1,
        MODE_BLUE    = 3'd2,
        MODE_BARS    = 3'd3,
        MODE_CHECKER = 3'd4,
        MODE_GRAD    = 3'd5
    } mode_e;

    localparam int NUM_MODES = 6;
    localparam int NUM_BARS  = 8;

    // On/off bits per bar as {R,G,B}; entry 0 is the leftmost bar.
    localparam logic [NUM_BARS-1:0][2:0] BAR_LUT = {
        3'b000,  // black
        3'b001,  // blue
        3'b100,  // red
        3'b101,  // magenta
        3'b010,  // green
        3'b011,  // cyan
        3'b110,  // yellow
        3'b111   // white
    };

    localparam int RGB_CHAN_W = 8;

    typedef struct packed {
        logic [RGB_CHAN_W-1:0] r;
        logic [RGB_CHAN_W-1:0] g;
        logic [RGB_CHAN_W-1:0] b;
    } rgb_t;

    // Step a mode up or down with wrap; simultaneous up and down cancel.
    function automatic mode_e mode_step(mode_e m, logic up, logic dn);
        mode_e r;
        r = m;
        if (up && !dn) begin
            r = (m == MODE_GRAD) ? MODE_RED : mode_e'(3'(m + 3'd1));
        end else if (dn && !up) begin
            r = (m == MODE_RED) ? MODE_GRAD : mode_e'(3'(m - 3'd1));
        end
        return r;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-key conditioner: 2-flop synchroniser, stability counter and rising-edge
// press pulse.
module key_debounce #(
    parameter int DEBOUNCE_CYC = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             meta;
    logic             synced;
    logic             level;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta   <= 1'b0;
            synced <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            meta   <= key;
            synced <= meta;
            press  <= 1'b0;
            if (synced == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Pulse coincides with the cycle the debounced level rises.
                level <= synced;
                press <= synced;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// Key-selectable test-pattern source with a fixed 2-cycle pixel pipeline;
// mode and invert changes take effect only at frame start.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int COLOR_W      = 8,
    parameter int X_W          = 10,
    parameter int Y_W          = 10,
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int NUM_KEYS     = 3,
    parameter int DEBOUNCE_CYC = 250000,
    parameter int SOLID_LEVEL  = 250,
    parameter int CHECKER_LOG2 = 5
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_KEYS-1:0]    i_key,
    input  logic                   i_frame_start,
    input  logic                   i_pix_req,
    input  logic [X_W-1:0]         i_x,
    input  logic [Y_W-1:0]         i_y,
    output logic [3*COLOR_W-1:0]   o_color,
    output logic                   o_color_valid,
    output logic [2:0]             o_mode
);

    if (X_W < COLOR_W) begin : g_bad_xw
        $error("vga_pattern_gen: X_W must be >= COLOR_W for the grey gradient");
    end
    if (NUM_KEYS != 3) begin : g_bad_keys
        $error("vga_pattern_gen: NUM_KEYS must be 3");
    end

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } pix_t;

    localparam int BAR_W = H_ACTIVE / NUM_BARS;
    localparam logic [COLOR_W-1:0] SOLID = COLOR_W'(SOLID_LEVEL);
    localparam logic [COLOR_W-1:0] ONES  = '1;

    logic [NUM_KEYS-1:0] press;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_key (
            .clk   (i_clk),
            .rst   (i_rst),
            .key   (i_key[k]),
            .press (press[k])
        );
    end

    mode_e pending;
    mode_e pending_nxt;
    mode_e active;
    logic  pend_inv;
    logic  pend_inv_nxt;
    logic  act_inv;

    always_comb begin
        pending_nxt  = mode_step(pending, press[0], press[1]);
        pend_inv_nxt = pend_inv ^ press[2];
    end

    // Commit uses the post-press pending value so a press on the frame-start
    // cycle is not lost for a whole frame.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pending  <= MODE_RED;
            pend_inv <= 1'b0;
            active   <= MODE_RED;
            act_inv  <= 1'b0;
        end else begin
            pending  <= pending_nxt;
            pend_inv <= pend_inv_nxt;
            if (i_frame_start) begin
                active  <= pending_nxt;
                act_inv <= pend_inv_nxt;
            end
        end
    end

    assign o_mode = active;

    logic           in_range;
    logic           s1_req;
    logic [X_W-1:0] s1_x;
    logic [Y_W-1:0] s1_y;
    logic           s1_in_range;
    mode_e          s1_mode;
    logic           s1_inv;

    assign in_range = (32'(i_x) < H_ACTIVE) && (32'(i_y) < V_ACTIVE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_req      <= 1'b0;
            s1_x        <= '0;
            s1_y        <= '0;
            s1_in_range <= 1'b0;
            s1_mode     <= MODE_RED;
            s1_inv      <= 1'b0;
        end else begin
            s1_req      <= i_pix_req;
            s1_x        <= i_x;
            s1_y        <= i_y;
            s1_in_range <= in_range;
            s1_mode     <= active;
            s1_inv      <= act_inv;
        end
    end

    logic [2:0]     bar_idx;
    logic [2:0]     bar_on;
    logic [X_W-1:0] cell_x;
    logic [Y_W-1:0] cell_y;
    logic           cell_on;
    pix_t           pix;
    logic [3*COLOR_W-1:0] color_nxt;

    always_comb begin
        bar_idx = '0;
        for (int i = 1; i < NUM_BARS; i++) begin
            if (32'(s1_x) >= i * BAR_W) begin
                bar_idx = 3'(i);
            end
        end
        bar_on  = BAR_LUT[bar_idx];
        cell_x  = s1_x >> CHECKER_LOG2;
        cell_y  = s1_y >> CHECKER_LOG2;
        cell_on = cell_x[0] ^ cell_y[0];

        pix = '0;
        case (s1_mode)
            MODE_RED:     pix.r = SOLID;
            MODE_GREEN:   pix.g = SOLID;
            MODE_BLUE:    pix.b = SOLID;
            MODE_BARS: begin
                pix.r = bar_on[2] ? ONES : '0;
                pix.g = bar_on[1] ? ONES : '0;
                pix.b = bar_on[0] ? ONES : '0;
            end
            MODE_CHECKER: pix = cell_on ? '1 : '0;
            MODE_GRAD: begin
                pix.r = s1_x[X_W-1 -: COLOR_W];
                pix.g = s1_x[X_W-1 -: COLOR_W];
                pix.b = s1_x[X_W-1 -: COLOR_W];
            end
            default:      pix = '0;
        endcase

        // Blanking stays black regardless of the invert setting.
        if (!s1_in_range) begin
            color_nxt = '0;
        end else if (s1_inv) begin
            color_nxt = ~pix;
        end else begin
            color_nxt = pix;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_color       <= '0;
            o_color_valid <= 1'b0;
        end else begin
            o_color_valid <= s1_req;
            if (s1_req) begin
                o_color <= color_nxt;
            end
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen with a short debounce window.
module tb_vga_pattern_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  key = '0;
    logic        frame_start = 1'b0;
    logic        pix_req = 1'b0;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic [23:0] o_color;
    logic        o_color_valid;
    logic [2:0]  o_mode;

    always #20 clk = ~clk;

    vga_pattern_gen #(
        .DEBOUNCE_CYC (4)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_key         (key),
        .i_frame_start (frame_start),
        .i_pix_req     (pix_req),
        .i_x           (x),
        .i_y           (y),
        .o_color       (o_color),
        .o_color_valid (o_color_valid),
        .o_mode        (o_mode)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit mon_en  = 1'b0;

    int exp_pend  = 0;
    int exp_mode  = 0;
    bit exp_pinv  = 1'b0;
    bit exp_inv   = 1'b0;

    typedef struct {
        logic [23:0] color;
        int          due;
    } exp_t;
    exp_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [23:0] model_color(int m, bit inv, int px, int py);
        logic [23:0] c;
        logic [7:0]  g;
        if (px >= 640 || py >= 480) return 24'h000000;
        case (m)
            0: c = 24'hFA0000;
            1: c = 24'h00FA00;
            2: c = 24'h0000FA;
            3: case (px / 80)
                   0: c = 24'hFFFFFF;
                   1: c = 24'hFFFF00;
                   2: c = 24'h00FFFF;
                   3: c = 24'h00FF00;
                   4: c = 24'hFF00FF;
                   5: c = 24'hFF0000;
                   6: c = 24'h0000FF;
                   default: c = 24'h000000;
               endcase
            4: c = (((px / 32) + (py / 32)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
            5: begin
                g = 8'(px / 4);
                c = {g, g, g};
            end
            default: c = 24'h000000;
        endcase
        return inv ? ~c : c;
    endfunction

    always @(negedge clk) begin : mon
        bit exp_v;
        if (mon_en) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                chk("sb_lost", cyc, sb[0].due);
                void'(sb.pop_front());
            end
            exp_v = (sb.size() > 0) && (sb[0].due == cyc);
            chk("valid", o_color_valid, exp_v);
            if (exp_v) begin
                chk("color", o_color, sb[0].color);
                void'(sb.pop_front());
            end
        end
    end

    task automatic req(int px, int py);
        @(posedge clk); #1;
        pix_req = 1'b1;
        x = 10'(px);
        y = 10'(py);
        sb.push_back('{color: model_color(exp_mode, exp_inv, px, py), due: cyc + 2});
        @(posedge clk); #1;
        pix_req = 1'b0;
    endtask

    task automatic drive_keys(logic [2:0] mask, int hold);
        @(posedge clk); #1;
        key = mask;
        repeat (hold) @(posedge clk);
        #1;
        key = '0;
        repeat (10) @(posedge clk);
    endtask

    task automatic press_key(int k);
        drive_keys(3'(1 << k), 6);
        case (k)
            0: exp_pend = (exp_pend + 1) % 6;
            1: exp_pend = (exp_pend + 5) % 6;
            default: exp_pinv = ~exp_pinv;
        endcase
    endtask

    task automatic frame(string tag);
        @(posedge clk); #1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        exp_mode = exp_pend;
        exp_inv  = exp_pinv;
        chk(tag, o_mode, exp_mode);
    endtask

    task automatic out_of_range();
        req(640, 0);
        req(0, 480);
        req(1023, 1023);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int bar_x[8] = '{0, 80, 559, 639, 79, 240, 400, 479};
        int guard;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", o_color_valid, 0);
        chk("rst_color", o_color, 0);
        chk("rst_mode", o_mode, 0);
        rst = 1'b0;
        mon_en = 1'b1;

        req(10, 10);

        press_key(0);
        frame("mode_k0");
        req(100, 100);

        drive_keys(3'b001, 2);
        frame("mode_glitch");

        press_key(1);
        frame("mode_k1_a");
        press_key(1);
        frame("mode_wrap5");
        req(639, 0);
        req(0, 0);
        req(320, 100);
        out_of_range();

        press_key(1);
        press_key(1);
        frame("mode_bars");
        foreach (bar_x[i]) req(bar_x[i], 0);
        out_of_range();

        press_key(2);
        frame("mode_bars_inv");
        req(0, 0);
        req(559, 0);
        out_of_range();
        press_key(2);
        frame("mode_bars_noinv");

        press_key(0);
        frame("mode_checker");
        req(0, 0);
        req(32, 0);
        req(32, 32);
        req(31, 33);
        req(100, 70);
        out_of_range();

        press_key(0);
        chk("mode_hold", o_mode, exp_mode);
        req(32, 0);
        frame("mode_commit");
        req(639, 0);

        drive_keys(3'b011, 6);
        frame("mode_k0k1");

        for (int m = 0; m < 3; m++) begin
            press_key(0);
            frame("mode_solid");
            req(5, 5);
            out_of_range();
        end

        // Reset with two requests in flight.
        repeat (3) @(posedge clk);
        mon_en = 1'b0;
        #1;
        pix_req = 1'b1;
        x = 10'd639;
        y = 10'd0;
        @(posedge clk); #1;
        x = 10'd600;
        @(posedge clk); #1;
        pix_req = 1'b0;
        chk("pre_rst_valid", o_color_valid, 1);
        chk("pre_rst_color", o_color, model_color(exp_mode, exp_inv, 639, 0));
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", o_color_valid, 0);
        chk("rst_mid_color", o_color, 0);
        chk("rst_mid_mode", o_mode, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_pend = 0; exp_mode = 0; exp_pinv = 1'b0; exp_inv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post_rst_valid", o_color_valid, 0);
        end
        mon_en = 1'b1;
        req(10, 10);
        req(700, 10);

        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (sb.size() > 0) chk("drain", sb.size(), 0);
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
Parametrised test-pattern source feeding the VGA controller's pixel colour input; replaces the fixed three-key solid-colour selector. Debounces push-keys, steps through six patterns, and returns one colour per pixel request with fixed 2-cycle latency. Mode changes are applied only at frame start, so no frame ever shows a mix of two patterns.

Parameters:
COLOR_W, 8, bits per colour channel (R, G, B)
X_W, 10, pixel x-coordinate width
Y_W, 10, pixel y-coordinate width
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
NUM_KEYS, 3, number of key inputs (fixed 3 for this release)
DEBOUNCE_CYC, 250000, stable cycles required to accept a key level (10 ms at 25 MHz)
SOLID_LEVEL, 250, channel level used in the solid modes
CHECKER_LOG2, 5, log2 of checkerboard square size in pixels

Ports:
i_clk  in  1  pixel clock (25 MHz)
i_rst  in  1  asynchronous, active-high reset
i_key  in  NUM_KEYS  raw keys, 1 = pressed, asynchronous to i_clk
i_frame_start  in  1  one-cycle pulse at the start of each frame, from the VGA controller
i_pix_req  in  1  pixel colour requested this cycle
i_x  in  X_W  x-coordinate of the requested pixel
i_y  in  Y_W  y-coordinate of the requested pixel
o_color  out  3*COLOR_W  {R,G,B}
o_color_valid  out  1  o_color corresponds to the request made 2 cycles earlier
o_mode  out  3  active mode, for debug LEDs

Behaviour:
- Reset (asynchronous, active-high): active mode 0, pending mode 0, invert 0, all debounce state 0, o_color 0, o_color_valid 0, o_mode 0.
- Key path, per key:
  - 2-flop synchroniser.
  - Counter clears whenever the synced level equals the debounced level.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYC-1, the debounced level flips and the counter clears.
  - A debounced 0->1 transition produces a one-cycle press pulse.
- Key actions:
  - key0 press: pending = (pending+1) mod 6.
  - key1 press: pending = (pending+5) mod 6, i.e. 0 wraps to 5.
  - key0 and key1 pressed in the same cycle: pending unchanged.
  - key2 press: toggles pending_invert, independent of the other keys.
- Frame-start commit:
  - On i_frame_start, active mode <= pending and active invert <= pending_invert.
  - If a press and i_frame_start occur in the same cycle, the commit uses the updated pending value.
- Modes (vga_pkg enum):
  - 0 solid red: {SOLID_LEVEL,0,0}.
  - 1 solid green: {0,SOLID_LEVEL,0}.
  - 2 solid blue: {0,0,SOLID_LEVEL}.
  - 3 colour bars: 8 equal vertical bars of width H_ACTIVE/8. From left: white, yellow, cyan, green, magenta, red, blue, black. "On" channels are all ones.
  - 4 checkerboard: white when bit 0 of ((x>>CHECKER_LOG2) ^ (y>>CHECKER_LOG2)) is 1, otherwise black.
  - 5 grey gradient: R=G=B = i_x[X_W-1 -: COLOR_W]. Elaboration error if X_W < COLOR_W.
- Coordinates with x >= H_ACTIVE or y >= V_ACTIVE: black, and the inversion is not applied.
- Invert: when active invert = 1, every channel of an in-range pixel is bitwise complemented.
- Pipeline:
  - Stage 1 registers the request, coordinates and range flag.
  - Stage 2 registers o_color and o_color_valid.
  - o_color_valid = i_pix_req delayed by 2 cycles.
  - o_color holds its last value when no request is valid.
  - Mode/invert values are sampled in stage 1.
- Reset asserted mid-frame clears the pipeline immediately; no valid output appears until 2 cycles after a new request.

Decomposition:
- Package vga_pkg holds:
  - mode_e enum (MODE_RED, MODE_GREEN, MODE_BLUE, MODE_BARS, MODE_CHECKER, MODE_GRAD) and NUM_MODES = 6;
  - colour-bar lookup constants (8 entries × 3 on/off bits);
  - the rgb_t packed struct.
- One sub-module, key_debounce (parameter DEBOUNCE_CYC): synchroniser, counter, debounced level and press pulse. Instantiated NUM_KEYS times.

Test Plan (DEBOUNCE_CYC=4 override):
- Reset, request (x=10, y=10) -> 2 cycles later o_color_valid=1, o_color=24'hFA0000; o_mode=0.
- key0 held 6 cycles, then i_frame_start pulse -> o_mode=1; request (100,100) returns 24'h00FA00. key0 glitch of 2 cycles -> mode unchanged.
- key1 pressed once from mode 0, then frame start -> o_mode=5; request x=639 -> 24'h9F9F9F; request x=0 -> 24'h000000.
- Mode 3: requests at x=0, 80, 559, 639 -> FFFFFF, FFFF00, 0000FF, 000000. With key2 pressed and committed at frame start, x=0 -> 000000.
- Mode 4: requests (0,0) -> 000000, (32,0) -> FFFFFF, (32,32) -> 000000. Out-of-range (640,0) and (0,480) -> 000000 in every mode.
- Press key0 mid-frame -> o_mode and pixel colours unchanged until the next i_frame_start. Key0+key1 pressed in the same cycle -> pending unchanged. Assert i_rst with requests in flight -> o_color_valid=0 and o_color=0 immediately.
